timer_compare_unit: RTL

Memory-mapped compare/interrupt stage that sits directly downstream of the 24-bit free-running peripheral counter. It consumes the counter's `count` bus and compares it against a programmable compare value. On a match it raises a sticky interrupt, snapshots the count, and emits a one-cycle restart pulse back to the counter. Software configures it through a small 4-register CPU bus interface; one-shot and periodic modes are supported.

---
 rtl/timer_compare_unit_if.sv | 24 ++
 rtl/timer_compare_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/timer_compare_unit_if.sv
// CPU register bus for timer_compare_unit.
// master drives strobes and addresses, slave returns read data.
interface timer_compare_unit_if #(
  parameter int WIDTH = 24
);
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [1:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/timer_compare_unit.sv
// Compare/interrupt stage downstream of the free-running counter.
// On match: sticky pending, capture count, one-cycle restart pulse.
module timer_compare_unit #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     count,
  timer_compare_unit_if.slave  bus,
  output logic                 cnt_restart,
  output logic                 match,
  output logic                 irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_MATCHED,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_ctrl;
  logic [WIDTH-1:0] r_cmp;
  logic             r_pending;
  logic             r_done;
  logic [WIDTH-1:0] r_capture;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_restart;
  logic             r_match;
  logic             r_eq_q;

  logic             w_eq;
  logic             w_hit;
  logic             w_arm;
  logic             w_match_ev;
  logic             w_wr_ctrl;
  logic             w_wr_cmp;
  logic             w_clr;
  logic [2:0]       w_ctrl_nxt;
  logic [WIDTH-1:0] w_rd_mux;

  assign w_eq  = (count == r_cmp);
  assign w_hit = w_eq & ~r_eq_q;

  assign w_wr_ctrl = bus.wr_en & (bus.wr_addr == 2'd0);
  assign w_wr_cmp  = bus.wr_en & (bus.wr_addr == 2'd1);
  assign w_clr     = bus.wr_en & (bus.wr_addr == 2'd2)
                   & bus.wr_data[0];

  assign w_ctrl_nxt = w_wr_ctrl ? bus.wr_data[2:0] : r_ctrl;

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_match_ev  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ctrl[0]) begin
          w_state_nxt = S_ARMED;
          w_arm       = 1'b1;
        end
      end
      S_ARMED: begin
        if (w_hit) begin
          w_state_nxt = S_MATCHED;
          w_match_ev  = 1'b1;
        end else if (!r_ctrl[0]) begin
          w_state_nxt = S_IDLE;
        end
      end
      // a disable landing on this edge wins over re-arm
      S_MATCHED: begin
        if (!w_ctrl_nxt[0])
          w_state_nxt = S_IDLE;
        else if (w_ctrl_nxt[1])
          w_state_nxt = S_ARMED;
        else
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!r_ctrl[0]) begin
          w_state_nxt = S_IDLE;
        end else if (r_ctrl[1]) begin
          w_state_nxt = S_ARMED;
          w_arm       = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.rd_addr)
      2'd0:    w_rd_mux[2:0] = r_ctrl;
      2'd1:    w_rd_mux      = r_cmp;
      2'd2:    w_rd_mux[1:0] = {r_done, r_pending};
      default: w_rd_mux      = r_capture;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_eq_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_eq_q  <= w_arm ? 1'b0 : w_eq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= '0;
      r_cmp  <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= bus.wr_data[2:0];
      if (w_wr_cmp)  r_cmp  <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_capture <= '0;
      r_restart <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_restart <= w_match_ev;
      r_match   <= w_match_ev;
      if (w_match_ev) begin
        r_pending <= 1'b1;
        r_capture <= count;
      end else if (w_clr) begin
        r_pending <= 1'b0;
      end
      if (w_arm)
        r_done <= 1'b0;
      else if (w_state_nxt == S_DONE)
        r_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_rd_data <= '0;
    else if (bus.rd_en)
      r_rd_data <= w_rd_mux;
  end

  assign bus.rd_data = r_rd_data;
  assign cnt_restart = r_restart;
  assign match       = r_match;
  assign irq         = r_pending & r_ctrl[2];

endmodule
